// File: rtl/icache_assoc_pf.sv
// N-way set-associative instruction cache with sequential prefetch and tagged multi-outstanding fills.
// Latency: hits are combinational (zero cycles); a filled line hits from the cycle after its data returns.
// Backpressure: a rejected request (response 0) retries the same block; issue holds while every MSHR is busy.
module icache_assoc_pf #(
    parameter int SETS     = 32,
    parameter int WAYS     = 2,
    parameter int PF_DEPTH = 3,
    parameter int MSHRS    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] proc2Icache_addr,
    input  logic [3:0]  Imem2proc_response,
    input  logic [63:0] Imem2proc_data,
    input  logic [3:0]  Imem2proc_tag,
    output logic [1:0]  proc2Imem_command,
    output logic [31:0] proc2Imem_addr,
    output logic [63:0] Icache_data_out,
    output logic        Icache_valid_out
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 13 - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int MSHR_W = (MSHRS > 1) ? $clog2(MSHRS) : 1;
    localparam int K_W    = (PF_DEPTH > 0) ? $clog2(PF_DEPTH + 1) : 1;

    localparam logic [1:0] BUS_NONE = 2'b00;
    localparam logic [1:0] BUS_LOAD = 2'b01;

    typedef enum logic {IDLE, ISSUE} state_t;

    // Line storage
    logic                line_vld_q [SETS][WAYS];
    logic [TAG_W-1:0]    line_tag_q [SETS][WAYS];
    logic [63:0]         line_dat_q [SETS][WAYS];
    logic [WAY_W-1:0]    rr_q       [SETS];

    // Miss status holding registers
    logic [MSHRS-1:0]    mshr_vld_q;
    logic [MSHRS-1:0]    mshr_drop_q;
    logic [3:0]          mshr_tag_q [MSHRS];
    logic [28:0]         mshr_blk_q [MSHRS];

    // Issue FSM state
    state_t              state_q, state_d;
    logic [28:0]         base_q, base_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [28:0]         prev_blk_q;

    // Demand and candidate address decode
    logic [28:0]         dem_blk;
    logic [IDX_W-1:0]    dem_idx;
    logic [TAG_W-1:0]    dem_tag;
    logic [28:0]         cand;
    logic [IDX_W-1:0]    cand_idx;
    logic [TAG_W-1:0]    cand_tag;
    logic                unused_addr_bits;

    assign dem_blk          = proc2Icache_addr[31:3];
    assign dem_idx          = dem_blk[IDX_W-1:0];
    assign dem_tag          = dem_blk[12:IDX_W];
    assign cand             = base_q + 29'(k_q);
    assign cand_idx         = cand[IDX_W-1:0];
    assign cand_tag         = cand[12:IDX_W];
    assign unused_addr_bits = ^proc2Icache_addr[2:0];

    logic                dem_hit, cand_hit;
    logic [63:0]         dem_dat;

    // Tag compare across the ways of the demand set and the prefetch-candidate set
    always_comb begin
        dem_hit  = 1'b0;
        dem_dat  = '0;
        cand_hit = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (line_vld_q[dem_idx][w] && (line_tag_q[dem_idx][w] == dem_tag)) begin
                dem_hit = 1'b1;
                dem_dat = line_dat_q[dem_idx][w];
            end
            if (line_vld_q[cand_idx][w] && (line_tag_q[cand_idx][w] == cand_tag)) begin
                cand_hit = 1'b1;
            end
        end
    end

    logic                dem_in_mshr, cand_in_mshr;
    logic                fill_hit, free_any;
    logic [MSHR_W-1:0]   fill_sel, free_sel;

    // MSHR lookups: block membership, returning-tag match and lowest free entry
    always_comb begin
        dem_in_mshr  = 1'b0;
        cand_in_mshr = 1'b0;
        fill_hit     = 1'b0;
        fill_sel     = '0;
        free_any     = 1'b0;
        free_sel     = '0;
        for (int m = MSHRS - 1; m >= 0; m--) begin
            if (mshr_vld_q[m] && (mshr_blk_q[m] == dem_blk)) begin
                dem_in_mshr = 1'b1;
            end
            if (mshr_vld_q[m] && (mshr_blk_q[m] == cand)) begin
                cand_in_mshr = 1'b1;
            end
            if (mshr_vld_q[m] && (Imem2proc_tag != 4'd0) && (mshr_tag_q[m] == Imem2proc_tag)) begin
                fill_hit = 1'b1;
                fill_sel = MSHR_W'(m);
            end
            if (!mshr_vld_q[m]) begin
                free_any = 1'b1;
                free_sel = MSHR_W'(m);
            end
        end
    end

    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                fill_wr;
    logic                way_match, way_inv, fill_use_rr;
    logic [WAY_W-1:0]    match_way, inv_way, fill_way, rr_nxt;

    assign fill_idx = mshr_blk_q[fill_sel][IDX_W-1:0];
    assign fill_tag = mshr_blk_q[fill_sel][12:IDX_W];
    // A flush in the same cycle wins over the fill; dropped entries never write
    assign fill_wr  = fill_hit && !mshr_drop_q[fill_sel] && !flush;

    // Fill way choice: same-tag way, else lowest invalid way, else round-robin victim
    always_comb begin
        way_match = 1'b0;
        way_inv   = 1'b0;
        match_way = '0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (line_vld_q[fill_idx][w] && (line_tag_q[fill_idx][w] == fill_tag)) begin
                way_match = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!line_vld_q[fill_idx][w]) begin
                way_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        fill_use_rr = !way_match && !way_inv;
        fill_way    = way_match ? match_way : (way_inv ? inv_way : rr_q[fill_idx]);
        rr_nxt      = (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[fill_idx] + WAY_W'(1);
    end

    logic                blk_changed, last_cand, alloc;
    logic [1:0]          cmd;
    logic [31:0]         cmd_addr;

    assign blk_changed = (dem_blk != prev_blk_q);
    assign last_cand   = (k_q == K_W'(PF_DEPTH));

    // Issue FSM next state and bus command
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        k_d      = k_q;
        cmd      = BUS_NONE;
        cmd_addr = '0;
        alloc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!dem_hit && !dem_in_mshr) begin
                    state_d = ISSUE;
                    base_d  = dem_blk;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                if (blk_changed) begin
                    // Fetch redirected: abandon the unissued tail of the old stream
                    if (!dem_hit && !dem_in_mshr) begin
                        base_d = dem_blk;
                        k_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cand_hit || cand_in_mshr) begin
                    k_d = k_q + K_W'(1);
                    if (last_cand) begin
                        state_d = IDLE;
                        k_d     = '0;
                    end
                end else if (free_any) begin
                    cmd      = BUS_LOAD;
                    cmd_addr = {cand, 3'b000};
                    if (Imem2proc_response != 4'd0) begin
                        alloc = 1'b1;
                        k_d   = k_q + K_W'(1);
                        if (last_cand) begin
                            state_d = IDLE;
                            k_d     = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush || reset) begin
            state_d  = IDLE;
            cmd      = BUS_NONE;
            cmd_addr = '0;
            alloc    = 1'b0;
        end
    end

    assign proc2Imem_command = cmd;
    assign proc2Imem_addr    = cmd_addr;
    assign Icache_data_out   = dem_dat;
    assign Icache_valid_out  = dem_hit && !reset;

    // FSM registers and MSHR allocate/free/drop
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            k_q         <= '0;
            prev_blk_q  <= '0;
            mshr_vld_q  <= '0;
            mshr_drop_q <= '0;
            for (int m = 0; m < MSHRS; m++) begin
                mshr_tag_q[m] <= '0;
                mshr_blk_q[m] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            k_q        <= k_d;
            prev_blk_q <= dem_blk;
            if (flush) begin
                mshr_drop_q <= mshr_drop_q | mshr_vld_q;
            end
            if (fill_hit) begin
                mshr_vld_q[fill_sel] <= 1'b0;
            end
            // free_sel was invalid at cycle start, so it never collides with fill_sel
            if (alloc) begin
                mshr_vld_q[free_sel]  <= 1'b1;
                mshr_drop_q[free_sel] <= 1'b0;
                mshr_tag_q[free_sel]  <= Imem2proc_response;
                mshr_blk_q[free_sel]  <= cand;
            end
        end
    end

    // Line valid/tag and round-robin pointer update
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    line_vld_q[s][w] <= 1'b0;
                end
            end
        end else if (fill_wr) begin
            line_vld_q[fill_idx][fill_way] <= 1'b1;
            line_tag_q[fill_idx][fill_way] <= fill_tag;
            if (fill_use_rr) begin
                rr_q[fill_idx] <= rr_nxt;
            end
        end
    end

    // Line data array, written only on accepted fills
    always_ff @(posedge clock) begin
        if (fill_wr && !reset) begin
            line_dat_q[fill_idx][fill_way] <= Imem2proc_data;
        end
    end

endmodule

// File: tb/tb_icache_assoc_pf.sv
// Directed bench for icache_assoc_pf with default parameters.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Memory responses and return tags are scripted cycle by cycle.
module tb_icache_assoc_pf;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [31:0] proc2Icache_addr;
    logic [3:0]  Imem2proc_response;
    logic [63:0] Imem2proc_data;
    logic [3:0]  Imem2proc_tag;
    logic [1:0]  proc2Imem_command;
    logic [31:0] proc2Imem_addr;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;

    int vectors    = 0;
    int miscompares = 0;

    icache_assoc_pf #(.SETS(32), .WAYS(2), .PF_DEPTH(3), .MSHRS(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .proc2Icache_addr   (proc2Icache_addr),
        .Imem2proc_response (Imem2proc_response),
        .Imem2proc_data     (Imem2proc_data),
        .Imem2proc_tag      (Imem2proc_tag),
        .proc2Imem_command  (proc2Imem_command),
        .proc2Imem_addr     (proc2Imem_addr),
        .Icache_data_out    (Icache_data_out),
        .Icache_valid_out   (Icache_valid_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [63:0] D1  = 64'h1111_0000_0000_0100;
    localparam logic [63:0] D2  = 64'h2222_0000_0000_0108;
    localparam logic [63:0] D3  = 64'h3333_0000_0000_0110;
    localparam logic [63:0] D4  = 64'h4444_0000_0000_0118;
    localparam logic [63:0] DX  = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] D9  = 64'h9999_0000_0000_0100;
    localparam logic [63:0] D10 = 64'hAAAA_0000_0000_0108;
    localparam logic [63:0] DA  = 64'hA0A0_0000_0000_0000;
    localparam logic [63:0] DB  = 64'hB0B0_0000_0000_0100;
    localparam logic [63:0] DC  = 64'hC0C0_0000_0000_0200;
    localparam logic [63:0] E1  = 64'hE1E1_0000_0000_0100;
    localparam logic [63:0] E2  = 64'hE2E2_0000_0000_0108;
    localparam logic [63:0] E3  = 64'hE3E3_0000_0000_0110;

    task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Expected {command, address}: BUS_LOAD = 1, BUS_NONE = 0 with address 0
    task automatic chk_load(input string name, input logic [31:0] a);
        chk(name, {38'd0, proc2Imem_command, proc2Imem_addr}, {38'd0, 2'b01, a});
    endtask

    task automatic chk_none(input string name);
        chk(name, {38'd0, proc2Imem_command, proc2Imem_addr}, 72'd0);
    endtask

    task automatic chk_hit(input string name, input logic [63:0] d);
        chk(name, {7'd0, Icache_valid_out, Icache_data_out}, {7'd0, 1'b1, d});
    endtask

    task automatic chk_miss(input string name);
        chk(name, {71'd0, Icache_valid_out}, 72'd0);
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] rsp,
                         input logic [3:0] t, input logic [63:0] d);
        @(negedge clock);
        reset              = 1'b0;
        flush              = 1'b0;
        proc2Icache_addr   = a;
        Imem2proc_response = rsp;
        Imem2proc_tag      = t;
        Imem2proc_data     = d;
        #1;
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        reset              = 1'b1;
        flush              = 1'b0;
        Imem2proc_response = 4'd0;
        Imem2proc_tag      = 4'd0;
        #1;
        chk_none({name, "_cmd"});
        chk_miss({name, "_vld"});
    endtask

    initial begin
        reset              = 1'b1;
        flush              = 1'b0;
        proc2Icache_addr   = 32'h100;
        Imem2proc_response = 4'd0;
        Imem2proc_data     = 64'd0;
        Imem2proc_tag      = 4'd0;

        // Cold miss at 0x100, four consecutive prefetch loads, out-of-order returns
        do_reset("rst0");
        drive(32'h100, 0, 0, 0);  chk_none("t1_idle"); chk_miss("t1_cold_miss");
        drive(32'h100, 1, 0, 0);  chk_load("t1_ld100", 32'h100);
        drive(32'h100, 2, 0, 0);  chk_load("t1_ld108", 32'h108);
        drive(32'h100, 3, 0, 0);  chk_load("t1_ld110", 32'h110);
        drive(32'h100, 4, 0, 0);  chk_load("t1_ld118", 32'h118);
        drive(32'h100, 0, 3, D3); chk_none("t1_wait_mshr"); chk_miss("t1_still_miss");
        drive(32'h100, 0, 1, D1); chk_miss("t1_no_bypass");
        drive(32'h100, 0, 2, D2); chk_hit("t1_hit100", D1);
        drive(32'h100, 0, 4, D4); chk_hit("t1_hit100b", D1);
        drive(32'h100, 0, 9, DX); chk_hit("t1_unmatched_tag", D1);
        drive(32'h108, 0, 0, 0);  chk_hit("t1_hit108", D2);
        drive(32'h110, 0, 0, 0);  chk_hit("t1_hit110", D3);
        drive(32'h118, 0, 0, 0);  chk_hit("t1_hit118", D4);
        // All four MSHRs freed: a new miss streams four loads back to back
        drive(32'h800, 0, 0, 0);  chk_none("t1b_idle"); chk_miss("t1b_miss800");
        drive(32'h800, 5, 0, 0);  chk_load("t1b_ld800", 32'h800);
        drive(32'h800, 6, 0, 0);  chk_load("t1b_ld808", 32'h808);
        drive(32'h800, 7, 0, 0);  chk_load("t1b_ld810", 32'h810);
        drive(32'h800, 8, 0, 0);  chk_load("t1b_ld818", 32'h818);

        // Reset mid-flight, rejects, then a redirect during ISSUE
        do_reset("rst1");
        drive(32'h100, 0, 5, DX); chk_none("t2_idle"); chk_miss("t2_reset_cleared");
        drive(32'h100, 0, 0, 0);  chk_load("t2_rej1", 32'h100);
        drive(32'h100, 0, 0, 0);  chk_load("t2_rej2", 32'h100);
        drive(32'h100, 9, 0, 0);  chk_load("t2_acc", 32'h100);
        drive(32'h100, 10, 0, 0); chk_load("t2_ld108", 32'h108);
        drive(32'h800, 0, 0, 0);  chk_none("t6_redirect_quiet");
        drive(32'h800, 11, 0, 0); chk_load("t6_ld800", 32'h800);
        drive(32'h800, 12, 0, 0); chk_load("t6_ld808", 32'h808);
        drive(32'h800, 0, 0, 0);  chk_none("t2_mshrs_full");
        drive(32'h800, 0, 10, D10); chk_none("t2_full_on_free");
        drive(32'h800, 0, 0, 0);  chk_load("t2_reuse_after_free", 32'h810);
        drive(32'h108, 0, 0, 0);  chk_hit("t6_old_fill108", D10); chk_none("t6_hit_quiet");
        drive(32'h108, 0, 9, D9); chk_hit("t6_hit108b", D10);
        drive(32'h100, 0, 0, 0);  chk_hit("t2_hit100", D9);

        // Round-robin eviction in set 0
        do_reset("rst2");
        drive(32'h000, 0, 0, 0);  chk_none("t4_idle");
        drive(32'h000, 1, 0, 0);  chk_load("t4_ld000", 32'h000);
        drive(32'h000, 0, 0, 0);  chk_load("t4_ld008", 32'h008);
        drive(32'h100, 0, 0, 0);  chk_none("t4_redir100");
        drive(32'h100, 2, 0, 0);  chk_load("t4_ld100", 32'h100);
        drive(32'h100, 0, 0, 0);  chk_load("t4_ld108", 32'h108);
        drive(32'h200, 0, 0, 0);  chk_none("t4_redir200");
        drive(32'h200, 3, 0, 0);  chk_load("t4_ld200", 32'h200);
        drive(32'h200, 0, 1, DA); chk_load("t4_ld208", 32'h208);
        drive(32'h200, 0, 2, DB); chk_load("t4_ld208b", 32'h208);
        drive(32'h000, 0, 0, 0);  chk_hit("t4_hit000", DA);
        drive(32'h100, 0, 0, 0);  chk_hit("t4_hit100", DB);
        drive(32'h100, 0, 3, DC); chk_hit("t4_hit100b", DB);
        drive(32'h100, 0, 0, 0);  chk_hit("t4_rr_keep100", DB);
        drive(32'h200, 0, 0, 0);  chk_hit("t4_hit200", DC);
        drive(32'h000, 0, 0, 0);  chk_miss("t4_rr_evict000");

        // Flush with two requests in flight
        do_reset("rst3");
        drive(32'h100, 0, 0, 0);  chk_none("t5_idle");
        drive(32'h100, 1, 0, 0);  chk_load("t5_ld100", 32'h100);
        drive(32'h100, 2, 0, 0);  chk_load("t5_ld108", 32'h108);
        drive(32'h100, 3, 0, 0);  chk_load("t5_ld110", 32'h110);
        drive(32'h100, 0, 1, E1); chk_load("t5_ld118", 32'h118);
        drive(32'h100, 0, 0, 0);  chk_hit("t5_hit_pre_flush", E1);
        drive(32'h100, 0, 0, 0);
        flush = 1'b1;
        #1;
        chk_none("t5_flush_quiet");
        drive(32'h100, 0, 0, 0);  chk_miss("t5_flush_inval"); chk_none("t5_post_flush_idle");
        drive(32'h100, 0, 2, E2); chk_load("t5_reissue100", 32'h100); chk_miss("t5_drop2_miss");
        drive(32'h100, 0, 3, E3); chk_miss("t5_drop3_miss");
        drive(32'h108, 0, 0, 0);  chk_miss("t5_108_empty"); chk_none("t5_redir_quiet");
        drive(32'h108, 4, 0, 0);  chk_load("t5_ld108", 32'h108);
        drive(32'h108, 5, 0, 0);  chk_load("t5_ld110", 32'h110);
        drive(32'h108, 6, 0, 0);  chk_load("t5_ld118", 32'h118);
        drive(32'h108, 7, 0, 0);  chk_load("t5_ld120", 32'h120);
        drive(32'h108, 0, 0, 0);  chk_none("t5_done_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_assoc_pf.md
Name: icache_assoc_pf

Overview:
- Parametrised instruction cache: N-way set-associative, with a configurable sequential prefetch depth and multiple outstanding tagged memory requests.
- Sits between fetch and the memory bus arbiter, using the same tagged BUS_LOAD protocol as the existing direct-mapped icache.
- Adds over the existing icache: associativity, a flush input, MSHR tracking, and out-of-order fill.

Parameters:
- SETS, 32: number of sets; power of 2, 2..1024.
- WAYS, 2: ways per set; power of 2, 1..8.
- PF_DEPTH, 3: blocks prefetched after a demand miss (0 disables prefetch).
- MSHRS, 4: maximum outstanding memory requests; 1..15.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush  in  1  invalidate whole cache and discard in-flight returns
- proc2Icache_addr  in  32  fetch address; bits [15:3] used for lookup
- Imem2proc_response  in  4  nonzero = request accepted, value is its tag; 0 = rejected
- Imem2proc_data  in  64  returned block
- Imem2proc_tag  in  4  tag of returned data; 0 = none
- proc2Imem_command  out  2  BUS_NONE / BUS_LOAD
- proc2Imem_addr  out  32  {block,3'b0}; 0 when command is BUS_NONE
- Icache_data_out  out  64  hit way data
- Icache_valid_out  out  1  hit

Behaviour:
- Address split: index = addr[3+log2(SETS)-1:3]; tag = addr[15:3+log2(SETS)]; block = addr[31:3].
- Lookup is combinational: hit when any way in the indexed set is valid with a matching tag. Data comes from that way. Zero-cycle latency.
- No fill bypass: a line filled at edge N produces a hit from cycle N onward, never in the cycle its data is on the bus.
- MSHR entry fields: valid, mem_tag[3:0], block[28:0], drop.
- Issue FSM, IDLE:
  - Demand miss whose block is not already held in a valid MSHR entry: base <= block, k <= 0, go to ISSUE.
  - Demand miss whose block is in an MSHR: stay IDLE and wait for the fill.
- Issue FSM, ISSUE, per cycle, candidate = base + k (mod 2^29):
  - Candidate already cached or in an MSHR: no command; k++ (one skip per cycle).
  - Otherwise, if an MSHR is free: drive BUS_LOAD with proc2Imem_addr = {candidate,3'b0}.
    - Response nonzero: allocate the lowest free MSHR with {1, response, candidate, 0}; k++.
    - Response 0: retry the same candidate next cycle.
  - All MSHRs valid: drive BUS_NONE and hold.
  - Once candidate k == PF_DEPTH is resolved: go to IDLE.
- Block change while in ISSUE (block differs from the previous cycle): drop unissued candidates immediately, with no command issued that cycle. Re-enter ISSUE with the new base if the new address misses and is not in an MSHR; otherwise go to IDLE. Already-issued entries still fill.
- Fill: Imem2proc_tag != 0 and it matches a valid MSHR entry.
  - drop = 0: write data into set(block). Way choice, in priority order:
    - the way already holding that tag;
    - else the lowest invalid way;
    - else the per-set round-robin victim, after which the pointer increments mod WAYS.
  - drop = 1: data discarded.
  - In both cases the entry frees at the same edge.
  - Unmatched tags are ignored.
- Allocation and free in the same cycle are both allowed; a freed entry is not reusable until the next cycle.
- Flush (edge-triggered effect, level input):
  - Clears all line valids and round-robin pointers.
  - Sets drop on all valid MSHRs.
  - FSM goes to IDLE; BUS_NONE that cycle.
  - Flush beats a simultaneous fill.
- Reset: all valids 0, MSHRs cleared, pointers 0, FSM IDLE. Outputs are command BUS_NONE, addr 0, Icache_valid_out 0, Icache_data_out don't-care.
- Reset mid-operation abandons all in-flight requests; later returns find no valid MSHR and are ignored.

Test Plan:
- Cold miss at 0x100 (PF_DEPTH=3, memory accepts tags 1..4) -> BUS_LOAD to 0x100, 0x108, 0x110, 0x118 on consecutive cycles. Each line then hits once its tag returns; 0x100 hits the cycle after tag 1 data.
- Memory rejects twice (response 0) -> proc2Imem_addr stays 0x100 for 3 cycles, and exactly one MSHR is allocated.
- Returns in order tag 3, 1, 2 -> each block fills its own set; no cross-write; all 3 MSHRs free.
- WAYS=2, SETS=32: fill 0x0000, 0x0100, 0x0200 (same set) -> third fill evicts 0x0000 via round-robin; 0x0100 still hits.
- Flush with 2 requests in flight -> valid_out 0 for all addresses; the later returns leave the cache empty; MSHRs free.
- Fetch jumps from 0x100 to 0x800 during ISSUE at k=1 -> no request for 0x110/0x118; the next command is 0x800; the 0x108 return still fills.
